uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter DATA_W, default 8, byte width; SHALL match the transmitter's tx_data width.
REQ-003 clk  input  1  sole clock; all logic SHALL be rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  host write strobe, one byte per cycle.
REQ-006 wr_data  input  DATA_W  host byte, sampled when wr_en=1.
REQ-007 full  output  1  high when DEPTH entries are stored.
REQ-008 empty  output  1  high when no entries are stored.
REQ-009 overflow  output  1  one-cycle pulse on a dropped write.
REQ-010 tx_start  output  1  one-cycle start pulse to the transmitter.
REQ-011 tx_data  output  DATA_W  byte to the transmitter, held stable from tx_start until tx_busy falls.
REQ-012 tx_busy  input  1  transmitter busy flag.
REQ-013 level  output  $clog2(DEPTH)+1  occupancy count; present only when UART_TX_FIFO_LEVEL_EN is defined.

Function
REQ-014 Write accepted iff wr_en=1 and full=0; entry stored at that edge; full/empty/level SHALL reflect it the next cycle.
REQ-015 wr_en=1 with full=1: byte SHALL be dropped, overflow=1 for the next cycle only, and FIFO contents SHALL be unchanged, even if a pop occurs in the same cycle.
REQ-016 Simultaneous accepted write and pop: both SHALL occur; occupancy unchanged; order preserved (FIFO).
REQ-017 Pointers SHALL be $clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full/empty SHALL derive from the MSB compare.
REQ-018 Issue FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE: if empty=0 and tx_busy=0, pop head into tx_data register, go to START; else stay.
REQ-020 START: tx_start=1 for exactly this cycle; go to WAIT_BUSY unconditionally.
REQ-021 WAIT_BUSY: on tx_busy=1 go to WAIT_DONE; else stay.
REQ-022 WAIT_DONE: on tx_busy=0 go to IDLE; else stay.
REQ-023 Latency: byte written at edge N into an empty FIFO, with tx_busy=0, SHALL give tx_start=1 in cycle N+2.
REQ-024 Back-to-back: next tx_start SHALL occur no earlier than 2 cycles after tx_busy falls.
REQ-025 tx_start SHALL never be high while tx_busy=1 was sampled in the preceding IDLE cycle.

Reset
REQ-026 rst=1: pointers cleared, empty=1, full=0, overflow=0, tx_start=0, tx_data=0, level=0, FSM=IDLE, at the next edge.
REQ-027 Reset mid-transmission SHALL discard all stored bytes; the in-flight byte is not re-issued.

Configuration
REQ-028 Macro UART_TX_FIFO_LEVEL_EN defined: level port present and equal to write-pointer minus read-pointer; undefined: port and its logic absent; all other behaviour identical.

Structure
REQ-029 The shared package uart_pkg SHALL hold the DATA_W default and the FSM state encoding typedef.
REQ-030 Storage SHALL be one sub-module, uart_sync_fifo (storage, pointers, flags); uart_tx_fifo adds the issue FSM and overflow logic.

Verification
REQ-031 Reset, then write 0xA5 with tx_busy=0 -> tx_start pulses in cycle N+2, tx_data=0xA5, empty=1 afterwards.
REQ-032 Write 16 bytes 0x00..0x0F with tx_busy held 1 -> full=1 after the 16th write; a 17th write of 0xFF -> overflow pulses 1 cycle, 0xFF never transmitted.
REQ-033 Transmitter model busy 10 cycles per byte, write 0x11, 0x22, 0x33 -> three tx_start pulses, bytes in order, each tx_start >= 2 cycles after tx_busy falls.
REQ-034 Full FIFO, write plus pop in the same cycle -> write dropped, overflow=1, level 16->15 (LEVEL_EN build).
REQ-035 rst asserted during WAIT_DONE with 5 bytes queued -> next cycle empty=1, tx_start=0, no further tx_start after release.
REQ-036 DEPTH=4, 12 bytes streamed -> pointer wrap exercised, all 12 bytes delivered in order, no spurious overflow.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//   UART_DATA_W  - default byte width used by the FIFO and the transmitter side
//   tx_state_e   - encoding of the transmit issue FSM
//   uart_cnt_w() - width of a FIFO pointer / occupancy count for a given depth
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

  // One extra bit over the address width lets full and empty be told apart
  // when the address bits of the two pointers are equal.
  function automatic int uart_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO (storage, pointers, flags).
//   clk, rst         - rising-edge clock, synchronous active-high reset
//   push, push_data  - write request; ignored while full
//   pop, pop_data    - read request; pop_data shows the head entry (ignored while empty)
//   full, empty      - occupancy flags, derived from the pointer compare
//   level            - occupancy count (only with UART_TX_FIFO_LEVEL_EN defined)
// DEPTH must be a power of two, at least 2.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
`ifdef UART_TX_FIFO_LEVEL_EN
 ,output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = uart_cnt_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // A push against a full FIFO is dropped even when a pop frees a slot in
  // the same cycle; the caller reports it as an overflow.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers run modulo 2*DEPTH: equal addresses with differing MSBs is full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pop_data = mem[rd_ptr[AW-1:0]];

`ifdef UART_TX_FIFO_LEVEL_EN
  assign level = wr_ptr - rd_ptr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: host-side byte FIFO feeding a UART transmitter.
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   wr_en, wr_data    - host write, one byte per cycle
//   full, empty       - FIFO occupancy flags
//   overflow          - one-cycle pulse the cycle after a write was dropped
//   tx_start, tx_data - start pulse and byte to the transmitter; tx_data is
//                       held until the next byte is issued
//   tx_busy           - transmitter busy flag
//   level             - occupancy count, present only when the macro
//                       UART_TX_FIFO_LEVEL_EN is defined
// Issue handshake: IDLE pops the head when the FIFO has data and the
// transmitter is idle, START pulses tx_start, then the FSM waits for tx_busy
// to rise and fall before looking at the FIFO again.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy
`ifdef UART_TX_FIFO_LEVEL_EN
 ,output logic [$clog2(DEPTH):0] level
`endif
);

  tx_state_e         state_q;
  tx_state_e         state_d;
  logic              pop;
  logic [DATA_W-1:0] pop_data;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty)
`ifdef UART_TX_FIFO_LEVEL_EN
   ,.level     (level)
`endif
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!empty && !tx_busy) state_d = START;
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs: the pop happens on the IDLE->START edge so tx_data is already
  // loaded while tx_start is high.
  always_comb begin
    pop      = 1'b0;
    tx_start = 1'b0;
    case (state_q)
      IDLE:    pop      = !empty && !tx_busy;
      START:   tx_start = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)      tx_data <= '0;
    else if (pop) tx_data <= pop_data;
  end

  // full is the pre-edge flag, so a write that races a pop on a full FIFO
  // is still reported as dropped.
  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else     overflow <= wr_en && full;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo (DEPTH 16 and DEPTH 4).
// A transmitter model raises tx_busy for a fixed number of cycles after each
// tx_start; a monitor compares every issued byte with a queue of bytes the
// host was expected to get accepted, and checks start spacing and tx_data hold.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       force_busy = 1'b0;
  logic       full, empty, overflow, tx_start, tx_busy;
  logic [7:0] tx_data;

  logic       wr_en4 = 1'b0;
  logic [7:0] wr_data4 = '0;
  logic       full4, empty4, overflow4, tx_start4, tx_busy4;
  logic [7:0] tx_data4;

`ifdef UART_TX_FIFO_LEVEL_EN
  logic [4:0] level;
  logic [2:0] level4;
`endif

  uart_tx_fifo #(.DEPTH(16), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .overflow(overflow),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
`ifdef UART_TX_FIFO_LEVEL_EN
   ,.level(level)
`endif
  );

  uart_tx_fifo #(.DEPTH(4), .DATA_W(8)) dut4 (
    .clk(clk), .rst(rst), .wr_en(wr_en4), .wr_data(wr_data4),
    .full(full4), .empty(empty4), .overflow(overflow4),
    .tx_start(tx_start4), .tx_data(tx_data4), .tx_busy(tx_busy4)
`ifdef UART_TX_FIFO_LEVEL_EN
   ,.level(level4)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter models: busy for a fixed time after each start pulse.
  int busy_cnt = 0;
  int busy4_cnt = 0;
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  always @(posedge clk) begin
    if (tx_start4) busy4_cnt <= 3;
    else if (busy4_cnt != 0) busy4_cnt <= busy4_cnt - 1;
  end
  assign tx_busy  = force_busy | (busy_cnt != 0);
  assign tx_busy4 = (busy4_cnt != 0);

  // Reference: bytes still owed to the transmitter, in order.
  logic [7:0] exp_q[$];
  logic [7:0] exp4_q[$];
  int         n_start = 0;
  int         n_start4 = 0;
  logic [7:0] held = '0;
  bit         in_flight = 1'b0;
  bit         prev_busy = 1'b0;
  int         fall_cyc = -100;

  task automatic mon_main();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        n_start++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_order: sent %02h, no byte expected", tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL tx_order: sent %02h, expected %02h", tx_data, e);
          end
        end
        checks++;
        if (prev_busy !== 1'b0) begin
          errors++;
          $display("FAIL start_while_busy: tx_busy before start=%b, expected 0", prev_busy);
        end
        checks++;
        if (cyc - fall_cyc < 2) begin
          errors++;
          $display("FAIL b2b_gap: start %0d cycles after busy fell, expected >= 2", cyc - fall_cyc);
        end
        held = tx_data;
        in_flight = 1'b1;
      end else if (in_flight && tx_busy) begin
        checks++;
        if (tx_data !== held) begin
          errors++;
          $display("FAIL tx_data_hold: tx_data=%02h while busy, expected %02h", tx_data, held);
        end
      end
      if (in_flight && prev_busy && !tx_busy) begin
        in_flight = 1'b0;
        fall_cyc = cyc;
      end
      if (rst) begin
        in_flight = 1'b0;
        fall_cyc = -100;
      end
      prev_busy = tx_busy;
    end
  endtask

  task automatic mon_dut4();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (tx_start4) begin
        n_start4++;
        checks++;
        if (exp4_q.size() == 0) begin
          errors++;
          $display("FAIL wrap_order: sent %02h, no byte expected", tx_data4);
        end else begin
          e = exp4_q.pop_front();
          if (tx_data4 !== e) begin
            errors++;
            $display("FAIL wrap_order: sent %02h, expected %02h", tx_data4, e);
          end
        end
      end
      if (overflow4) begin
        checks++;
        errors++;
        $display("FAIL wrap_overflow: overflow=1, expected 0");
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wr4(input logic [7:0] d);
    wr_en4 = 1'b1;
    wr_data4 = d;
    tick();
    wr_en4 = 1'b0;
  endtask

  // Let the transmitter finish, then reset the DUTs and the reference.
  task automatic quiet_reset();
    int n = 0;
    force_busy = 1'b0;
    while (tx_busy && n < 50) begin
      tick();
      n++;
    end
    exp_q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int max, output bit done);
    int n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < max) begin
      tick();
      n++;
    end
    done = (exp_q.size() == 0);
  endtask

  task automatic test_reset();
    int s;
    rst = 1'b1;
    tick();
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL reset_empty: got %b, want 1", empty); end
    checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b, want 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, want 0", overflow); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b, want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %02h, want 00", tx_data); end
`ifdef UART_TX_FIFO_LEVEL_EN
    checks++; if (level !== 5'd0)    begin errors++; $display("FAIL reset_level: got %0d, want 0", level); end
`endif
    rst = 1'b0;
    // Stored bytes must vanish on reset and never be sent.
    force_busy = 1'b1;
    wr(8'h01); wr(8'h02); wr(8'h03);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL reset_fill_empty: got %b, want 0", empty); end
`ifdef UART_TX_FIFO_LEVEL_EN
    checks++; if (level !== 5'd3) begin errors++; $display("FAIL reset_fill_level: got %0d, want 3", level); end
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_discard_empty: got %b, want 1", empty); end
    s = n_start;
    force_busy = 1'b0;
    repeat (10) tick();
    checks++; if (n_start != s) begin errors++; $display("FAIL reset_discard_sent: %0d starts, want 0", n_start - s); end
  endtask

  task automatic test_latency();
    bit done;
    quiet_reset();
    exp_q.push_back(8'hA5);
    wr(8'hA5);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL latency_n1_start: got %b, want 0", tx_start); end
    checks++; if (empty !== 1'b0)    begin errors++; $display("FAIL latency_n1_empty: got %b, want 0", empty); end
    tick();
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL latency_n2_start: got %b, want 1", tx_start); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL latency_data: got %02h, want a5", tx_data); end
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL latency_empty: got %b, want 1", empty); end
    wait_drain(100, done);
    checks++; if (!done) begin errors++; $display("FAIL latency_drain: %0d bytes left, want 0", exp_q.size()); end
  endtask

  task automatic test_full_overflow();
    bit done;
    quiet_reset();
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      wr(8'(i));
      checks++;
      if (full !== (i == 15)) begin errors++; $display("FAIL fill_full: after write %0d got %b, want %b", i, full, i == 15); end
`ifdef UART_TX_FIFO_LEVEL_EN
      checks++;
      if (level !== 5'(i + 1)) begin errors++; $display("FAIL fill_level: got %0d, want %0d", level, i + 1); end
`endif
    end
    wr(8'hFF);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_pulse: got %b, want 1", overflow); end
    tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %b, want 0", overflow); end
    checks++; if (full !== 1'b1)     begin errors++; $display("FAIL overflow_full: got %b, want 1", full); end
    force_busy = 1'b0;
    wait_drain(400, done);
    checks++; if (!done) begin errors++; $display("FAIL full_drain: %0d bytes left, want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit done;
    int s;
    quiet_reset();
    s = n_start;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    wr(8'h11); wr(8'h22); wr(8'h33);
    wait_drain(200, done);
    checks++; if (!done) begin errors++; $display("FAIL b2b_drain: %0d bytes left, want 0", exp_q.size()); end
    checks++; if (n_start - s != 3) begin errors++; $display("FAIL b2b_count: %0d starts, want 3", n_start - s); end
  endtask

  task automatic test_full_write_pop();
    bit done;
    logic [7:0] b;
    quiet_reset();
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      wr(b);
    end
    force_busy = 1'b0;
    wr(8'hEE);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL wpop_overflow: got %b, want 1", overflow); end
    checks++; if (full !== 1'b0)     begin errors++; $display("FAIL wpop_full: got %b, want 0", full); end
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL wpop_start: got %b, want 1", tx_start); end
`ifdef UART_TX_FIFO_LEVEL_EN
    checks++; if (level !== 5'd15)   begin errors++; $display("FAIL wpop_level: got %0d, want 15", level); end
`endif
    wait_drain(400, done);
    checks++; if (!done) begin errors++; $display("FAIL wpop_drain: %0d bytes left, want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int s;
    logic [7:0] b;
    quiet_reset();
    s = n_start;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      wr(b);
    end
    checks++; if (tx_busy !== 1'b1)  begin errors++; $display("FAIL rmid_busy: got %b, want 1", tx_busy); end
    checks++; if (n_start - s != 1)  begin errors++; $display("FAIL rmid_issued: %0d starts, want 1", n_start - s); end
    exp_q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL rmid_empty: got %b, want 1", empty); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rmid_start: got %b, want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rmid_data: got %02h, want 00", tx_data); end
    s = n_start;
    repeat (40) tick();
    checks++; if (n_start != s) begin errors++; $display("FAIL rmid_reissue: %0d starts, want 0", n_start - s); end
  endtask

  task automatic test_random();
    bit done;
    logic [7:0] b;
    quiet_reset();
    for (int i = 0; i < 14; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      wr(b);
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL rand_overflow: got %b, want 0", overflow); end
      repeat ($urandom_range(3)) tick();
    end
    wait_drain(600, done);
    checks++; if (!done) begin errors++; $display("FAIL rand_drain: %0d bytes left, want 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    int s;
    s = n_start4;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        b = 8'($urandom);
        exp4_q.push_back(b);
        wr4(b);
      end
      repeat (40) tick();
    end
    checks++; if (exp4_q.size() != 0) begin errors++; $display("FAIL wrap_drain: %0d bytes left, want 0", exp4_q.size()); end
    checks++; if (n_start4 - s != 12) begin errors++; $display("FAIL wrap_count: %0d starts, want 12", n_start4 - s); end
    checks++; if (empty4 !== 1'b1)    begin errors++; $display("FAIL wrap_empty: got %b, want 1", empty4); end
    checks++; if (full4 !== 1'b0)     begin errors++; $display("FAIL wrap_full: got %b, want 0", full4); end
  endtask

  initial begin
    fork
      mon_main();
      mon_dut4();
    join_none
    test_reset();
    test_latency();
    test_full_overflow();
    test_back_to_back();
    test_full_write_pop();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
